// File: rtl/lease_table_loader_pkg.sv
// Shared definitions for the lease table loader: table selectors, the
// default-lease config address and the sequencer state encoding.
package lease_table_loader_pkg;

  localparam logic [1:0] LLT_TBL_ADDR   = 2'd0;
  localparam logic [1:0] LLT_TBL_LEASE0 = 2'd1;
  localparam logic [1:0] LLT_TBL_LEASE1 = 2'd2;
  localparam logic [1:0] LLT_TBL_PROB   = 2'd3;

  localparam int LEASE_CFG_DEFAULT_ADDR = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DEFAULT = 3'd1,
    ST_COUNT   = 3'd2,
    ST_TABLE   = 3'd3,
    ST_CHECK   = 3'd4,
    ST_FINISH  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/lease_table_loader.sv
// Lease table loader: streams the default lease, the entry count and four
// LLT tables from a valid/ready word stream into the cache write ports.
// Optional trailing checksum word enabled by LEASE_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start_i
// DEFAULT | accept default lease word, write config register
// COUNT   | accept entry count C, range-check it
// TABLE   | accept C words for each of tables 0..3
// CHECK   | accept checksum word (checksum build only)
// FINISH  | done_o high for one cycle, busy_o low
module lease_table_loader
  import lease_table_loader_pkg::*;
#(
  parameter int N_ENTRIES     = 128,
  parameter int BW_ENTRIES    = $clog2(N_ENTRIES),
  parameter int BW_ADDR_SPACE = BW_ENTRIES + 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [31:0]              s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic                     con_wren_o,
  output logic                     llt_wren_o,
  output logic [BW_ADDR_SPACE-1:0] llt_addr_o,
  output logic [31:0]              llt_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o
);

  localparam logic [BW_ENTRIES:0] CNT_ONE = {{BW_ENTRIES{1'b0}}, 1'b1};

  loader_state_e            state_q;
  logic [BW_ENTRIES-1:0]    index_q;
  logic [1:0]               tbl_q;
  logic [BW_ENTRIES:0]      count_q;
  logic                     con_wren_q;
  logic                     llt_wren_q;
  logic [BW_ADDR_SPACE-1:0] addr_q;
  logic [31:0]              data_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     error_q;
  logic                     last_idx;
  logic                     count_bad;
`ifdef LEASE_LOADER_CHECKSUM_EN
  logic [31:0]              sum_q;
`endif

  // Ready is a pure decode of the state register, so it has no combinational
  // path from s_valid_i.
  assign s_ready_o = (state_q == ST_DEFAULT) || (state_q == ST_COUNT) ||
                     (state_q == ST_TABLE)   || (state_q == ST_CHECK);

  // Compare against the full word so large counts cannot alias into range.
  assign count_bad = (s_data_i == 32'd0) || (s_data_i > 32'(N_ENTRIES));
  assign last_idx  = ({1'b0, index_q} == (count_q - CNT_ONE));

  // Sequencer with registered write port and status outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      tbl_q      <= LLT_TBL_ADDR;
      count_q    <= '0;
      con_wren_q <= 1'b0;
      llt_wren_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LEASE_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      con_wren_q <= 1'b0;
      llt_wren_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef LEASE_LOADER_CHECKSUM_EN
      if (s_valid_i && (state_q == ST_DEFAULT || state_q == ST_COUNT || state_q == ST_TABLE))
        sum_q <= sum_q + s_data_i;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_DEFAULT;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            index_q <= '0;
            tbl_q   <= LLT_TBL_ADDR;
`ifdef LEASE_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
        ST_DEFAULT: begin
          if (s_valid_i) begin
            con_wren_q <= 1'b1;
            addr_q     <= BW_ADDR_SPACE'(LEASE_CFG_DEFAULT_ADDR);
            data_q     <= s_data_i;
            state_q    <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (s_valid_i) begin
            if (count_bad) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_FINISH;
            end else begin
              count_q <= s_data_i[BW_ENTRIES:0];
              state_q <= ST_TABLE;
            end
          end
        end
        ST_TABLE: begin
          if (s_valid_i) begin
            llt_wren_q <= 1'b1;
            addr_q     <= {tbl_q, index_q};
            data_q     <= s_data_i;
            if (last_idx) begin
              index_q <= '0;
              case (tbl_q)
                LLT_TBL_ADDR:   tbl_q <= LLT_TBL_LEASE0;
                LLT_TBL_LEASE0: tbl_q <= LLT_TBL_LEASE1;
                LLT_TBL_LEASE1: tbl_q <= LLT_TBL_PROB;
                default: begin
`ifdef LEASE_LOADER_CHECKSUM_EN
                  state_q <= ST_CHECK;
`else
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
`endif
                end
              endcase
            end else begin
              index_q <= index_q + 1'b1;
            end
          end
        end
`ifdef LEASE_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (s_valid_i) begin
            if (s_data_i != sum_q) error_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end
        end
`endif
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign con_wren_o = con_wren_q;
  assign llt_wren_o = llt_wren_q;
  assign llt_addr_o = addr_q;
  assign llt_data_o = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_lease_table_loader.sv
// Directed bench for lease_table_loader (N_ENTRIES=128). Honours
// LEASE_LOADER_CHECKSUM_EN to expect the trailing checksum word.
module tb_lease_table_loader;

  localparam int N   = 128;
  localparam int BWA = 9;

  logic           clock_i = 1'b0;
  logic           reset_i = 1'b1;
  logic           start_i = 1'b0;
  logic [31:0]    s_data_i = '0;
  logic           s_valid_i = 1'b0;
  logic           s_ready_o;
  logic           con_wren_o;
  logic           llt_wren_o;
  logic [BWA-1:0] llt_addr_o;
  logic [31:0]    llt_data_o;
  logic           busy_o;
  logic           done_o;
  logic           error_o;

  int n_vec = 0;
  int n_miscmp = 0;

  lease_table_loader #(.N_ENTRIES(N)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .con_wren_o(con_wren_o), .llt_wren_o(llt_wren_o),
    .llt_addr_o(llt_addr_o), .llt_data_o(llt_data_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " s_ready"}, 32'(s_ready_o), 32'd0);
    chk({tag, " con_wren"}, 32'(con_wren_o), 32'd0);
    chk({tag, " llt_wren"}, 32'(llt_wren_o), 32'd0);
    chk({tag, " addr"}, 32'(llt_addr_o), 32'd0);
    chk({tag, " data"}, llt_data_o, 32'd0);
    chk({tag, " busy"}, 32'(busy_o), 32'd0);
    chk({tag, " done"}, 32'(done_o), 32'd0);
    chk({tag, " error"}, 32'(error_o), 32'd0);
  endtask

  // kind: 0 = config write, 1 = LLT write, 2 = no write expected
  task automatic send(input logic [31:0] w, input int kind, input logic [BWA-1:0] exp_addr);
    int n;
    @(negedge clock_i);
    s_valid_i = 1'b1;
    s_data_i  = w;
    n = 0;
    while (!s_ready_o && n < 20) begin
      @(negedge clock_i);
      n++;
    end
    chk("ready_timeout", 32'(s_ready_o), 32'd1);
    @(posedge clock_i);
    #1;
    chk("con_wren", 32'(con_wren_o), 32'(kind == 0));
    chk("llt_wren", 32'(llt_wren_o), 32'(kind == 1));
    if (kind != 2) begin
      chk("wr_addr", 32'(llt_addr_o), 32'(exp_addr));
      chk("wr_data", llt_data_o, w);
    end
  endtask

  task automatic gap();
    @(negedge clock_i);
    s_valid_i = 1'b0;
    @(posedge clock_i);
    #1;
    chk("gap con_wren", 32'(con_wren_o), 32'd0);
    chk("gap llt_wren", 32'(llt_wren_o), 32'd0);
  endtask

  task automatic do_start();
    @(negedge clock_i);
    start_i = 1'b1;
    @(posedge clock_i);
    #1;
    start_i = 1'b0;
    chk("start busy", 32'(busy_o), 32'd1);
    chk("start error_clr", 32'(error_o), 32'd0);
    chk("start ready", 32'(s_ready_o), 32'd1);
  endtask

  function automatic logic [31:0] tword(input int t, input int i);
    return 32'((t + 1) << 24) | 32'h0000_5500 | 32'(i);
  endfunction

  task automatic do_load(input int c, input bit stall, input bit bad_sum);
    logic [31:0] sum;
    logic [31:0] w;
    do_start();
    w = 32'h100 + 32'(c);
    sum = w;
    send(w, 0, '0);
    if (stall) gap();
    sum += 32'(c);
    send(32'(c), 2, '0);
    if (stall) gap();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < c; i++) begin
        w = tword(t, i);
        sum += w;
        send(w, 1, BWA'((t << 7) | i));
        if (!(t == 3 && i == c - 1)) begin
          chk("mid busy", 32'(busy_o), 32'd1);
          chk("mid done", 32'(done_o), 32'd0);
          if (stall) gap();
        end
      end
    end
`ifdef LEASE_LOADER_CHECKSUM_EN
    chk("pre_check done", 32'(done_o), 32'd0);
    if (stall) gap();
    send(bad_sum ? sum + 32'd1 : sum, 2, '0);
`endif
    chk("end done", 32'(done_o), 32'd1);
    chk("end busy", 32'(busy_o), 32'd0);
`ifdef LEASE_LOADER_CHECKSUM_EN
    chk("end error", 32'(error_o), 32'(bad_sum));
`else
    chk("end error", 32'(error_o), 32'd0);
`endif
    // start_i coincident with done_o must be ignored
    @(negedge clock_i);
    s_valid_i = 1'b0;
    start_i = 1'b1;
    @(posedge clock_i);
    #1;
    start_i = 1'b0;
    chk("post done_pulse", 32'(done_o), 32'd0);
    chk("start_during_done busy", 32'(busy_o), 32'd0);
    chk("post ready", 32'(s_ready_o), 32'd0);
  endtask

  task automatic do_bad(input logic [31:0] c);
    do_start();
    send(32'h77, 0, '0);
    send(c, 2, '0);
    chk("bad error", 32'(error_o), 32'd1);
    chk("bad done", 32'(done_o), 32'd1);
    chk("bad busy", 32'(busy_o), 32'd0);
    @(negedge clock_i);
    s_valid_i = 1'b0;
    @(posedge clock_i);
    #1;
    chk("bad sticky error", 32'(error_o), 32'd1);
    chk("bad done_once", 32'(done_o), 32'd0);
    chk("bad no_llt", 32'(llt_wren_o), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock_i);
    #1;
    chk_idle_outputs("reset");
    @(negedge clock_i);
    reset_i = 1'b0;

    do_load(2, 1'b0, 1'b0);
    do_load(2, 1'b1, 1'b0);

    do_bad(32'd0);
    do_bad(32'(N + 1));
    do_bad(32'h0000_0101);

    do_load(N, 1'b0, 1'b0);
    chk("full last addr", 32'(llt_addr_o), 32'h1FF);

    // reset during table 1
    do_start();
    send(32'h9, 0, '0);
    send(32'd2, 2, '0);
    send(tword(0, 0), 1, 9'h000);
    send(tword(0, 1), 1, 9'h001);
    send(tword(1, 0), 1, 9'h080);
    @(negedge clock_i);
    s_valid_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clock_i);
    #1;
    chk_idle_outputs("midreset");
    @(negedge clock_i);
    reset_i = 1'b0;
    do_load(3, 1'b0, 1'b0);

`ifdef LEASE_LOADER_CHECKSUM_EN
    do_load(2, 1'b0, 1'b1);
    do_load(2, 1'b1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
